// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Multicycle LEGv8-subset control FSM with memory handshake and a
//            wait-cycle timeout. Define MULTICYCLE_IMM_EN to add ADDI/SUBI.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic        zero_E,
    input  logic        mem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        memRead,
    output logic        memWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        AluSrc,
    output logic        regWrite,
    output logic        memtoReg,
    output logic [3:0]  AluControl,
    output logic        err
);

    localparam logic [2:0] c_FETCH  = 3'd0;
    localparam logic [2:0] c_DECODE = 3'd1;
    localparam logic [2:0] c_EXEC   = 3'd2;
    localparam logic [2:0] c_MEM    = 3'd3;
    localparam logic [2:0] c_WB     = 3'd4;
    localparam logic [2:0] c_HALT   = 3'd5;

    localparam logic [2:0] c_CLS_ILL  = 3'd0;
    localparam logic [2:0] c_CLS_LDUR = 3'd1;
    localparam logic [2:0] c_CLS_STUR = 3'd2;
    localparam logic [2:0] c_CLS_CBZ  = 3'd3;
    localparam logic [2:0] c_CLS_RTYP = 3'd4;
    localparam logic [2:0] c_CLS_IMM  = 3'd5;

    localparam logic [3:0] c_ALU_AND   = 4'b0000;
    localparam logic [3:0] c_ALU_ORR   = 4'b0001;
    localparam logic [3:0] c_ALU_ADD   = 4'b0010;
    localparam logic [3:0] c_ALU_SUB   = 4'b0110;
    localparam logic [3:0] c_ALU_PASSB = 4'b0111;

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    logic [2:0]         r_state;
    logic [2:0]         w_nextState;
    logic [2:0]         r_cls;
    logic [3:0]         r_aluOp;
    logic [2:0]         w_cls;
    logic [3:0]         w_aluOp;
    logic [c_CNT_W-1:0] r_waitCnt;
    logic               r_err;
    logic               w_waiting;
    logic               w_timeout;

    always_comb begin
        w_cls   = c_CLS_ILL;
        w_aluOp = c_ALU_ADD;
        casez (opcode)
            11'b11111000010: w_cls = c_CLS_LDUR;
            11'b11111000000: w_cls = c_CLS_STUR;
            11'b10110100???: begin w_cls = c_CLS_CBZ;  w_aluOp = c_ALU_PASSB; end
            11'b10001011000: begin w_cls = c_CLS_RTYP; w_aluOp = c_ALU_ADD;   end
            11'b11001011000: begin w_cls = c_CLS_RTYP; w_aluOp = c_ALU_SUB;   end
            11'b10001010000: begin w_cls = c_CLS_RTYP; w_aluOp = c_ALU_AND;   end
            11'b10101010000: begin w_cls = c_CLS_RTYP; w_aluOp = c_ALU_ORR;   end
`ifdef MULTICYCLE_IMM_EN
            11'b1001000100?: begin w_cls = c_CLS_IMM;  w_aluOp = c_ALU_ADD;   end
            11'b1101000100?: begin w_cls = c_CLS_IMM;  w_aluOp = c_ALU_SUB;   end
`else
            11'b1001000100?: w_cls = c_CLS_ILL;
            11'b1101000100?: w_cls = c_CLS_ILL;
`endif
            default:         w_cls = c_CLS_ILL;
        endcase
    end

    // Timeout fires only when the TIMEOUT-th wait cycle also lacks an ack.
    assign w_waiting = (r_state == c_FETCH) || (r_state == c_MEM);
    assign w_timeout = w_waiting && !mem_ack &&
                       (r_waitCnt == c_CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_waitCnt <= '0;
            r_err     <= 1'b0;
            r_cls     <= c_CLS_ILL;
            r_aluOp   <= c_ALU_AND;
        end else begin
            if (w_nextState != r_state) begin
                r_waitCnt <= '0;
            end else if (w_waiting) begin
                r_waitCnt <= r_waitCnt + c_CNT_W'(1);
            end
            if (w_nextState == c_HALT) begin
                r_err <= 1'b1;
            end
            if (r_state == c_DECODE) begin
                r_cls   <= w_cls;
                r_aluOp <= w_aluOp;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_FETCH: begin
                if (mem_ack)        w_nextState = c_DECODE;
                else if (w_timeout) w_nextState = c_HALT;
            end
            c_DECODE: w_nextState = (w_cls == c_CLS_ILL) ? c_HALT : c_EXEC;
            c_EXEC: begin
                if (r_cls == c_CLS_LDUR || r_cls == c_CLS_STUR) w_nextState = c_MEM;
                else if (r_cls == c_CLS_CBZ)                    w_nextState = c_FETCH;
                else                                            w_nextState = c_WB;
            end
            c_MEM: begin
                if (mem_ack)        w_nextState = (r_cls == c_CLS_LDUR) ? c_WB : c_FETCH;
                else if (w_timeout) w_nextState = c_HALT;
            end
            c_WB:     w_nextState = c_FETCH;
            c_HALT:   w_nextState = c_HALT;
            default:  w_nextState = c_FETCH;
        endcase
    end

    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;
        AluSrc     = 1'b0;
        regWrite   = 1'b0;
        memtoReg   = 1'b0;
        AluControl = 4'b0000;
        err        = r_err;
        case (r_state)
            c_FETCH: begin
                imem_req = 1'b1;
                // Reset forces FETCH; keep an ack during reset from pulsing writes.
                IRWrite  = mem_ack && reset;
                PCWrite  = mem_ack && reset;
            end
            c_EXEC: begin
                AluControl = r_aluOp;
                case (r_cls)
                    c_CLS_LDUR, c_CLS_STUR: begin
                        AluSrc     = 1'b1;
                        AluControl = c_ALU_ADD;
                    end
                    c_CLS_IMM:  AluSrc = 1'b1;
                    c_CLS_CBZ: begin
                        PCWrite = zero_E;
                        PCSrc   = zero_E;
                    end
                    default:    AluSrc = 1'b0;
                endcase
            end
            c_MEM: begin
                dmem_req = 1'b1;
                memRead  = (r_cls == c_CLS_LDUR);
                memWrite = (r_cls == c_CLS_STUR);
            end
            c_WB: begin
                regWrite = 1'b1;
                memtoReg = (r_cls == c_CLS_LDUR);
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// Testbench for multicycle_control: instruction-level trace model with a
// per-cycle compare process plus literal checks on lengths and reset behaviour.
module tb_multicycle_control;
    localparam int TIMEOUT = 15;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_ADDI = 11'b10010001001;
    localparam logic [10:0] OP_SUBI = 11'b11010001000;
    localparam logic [10:0] OP_BAD  = 11'b11111111111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] opcode = '0;
    logic        zero_E = 1'b0;
    logic        mem_ack = 1'b0;
    logic        imem_req, dmem_req, memRead, memWrite, IRWrite, PCWrite;
    logic        PCSrc, AluSrc, regWrite, memtoReg, err;
    logic [3:0]  AluControl;
    logic [13:0] actVec;

    int errors = 0;
    int checks = 0;
    logic [13:0] expQ[$];

    int cyc = 0, lastIr = 0, gap = 0;
    int dmemCount = 0, memWrCount = 0, regWrCount = 0;

    always #5 clk = ~clk;

    multicycle_control #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero_E(zero_E),
        .mem_ack(mem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
        .memRead(memRead), .memWrite(memWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .AluSrc(AluSrc),
        .regWrite(regWrite), .memtoReg(memtoReg), .AluControl(AluControl),
        .err(err)
    );

    assign actVec = {imem_req, dmem_req, memRead, memWrite, IRWrite, PCWrite,
                     PCSrc, AluSrc, regWrite, memtoReg, AluControl, err};

    // Per-cycle comparison against the expected trace.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            logic [13:0] e;
            e = expQ.pop_front();
            checks++;
            if (actVec !== e) begin
                errors++;
                $display("FAIL trace t=%0t op=%b actual=%b required=%b (imem,dmem,rd,wr,ir,pcw,pcs,asrc,rw,m2r,alu[4],err)",
                         $time, opcode, actVec, e);
            end
        end
    end

    always @(negedge clk) begin
        if (dmem_req) dmemCount++;
        if (memWrite) memWrCount++;
        if (regWrite) regWrCount++;
        if (reset) begin
            cyc++;
            if (IRWrite) begin
                gap = cyc - lastIr;
                lastIr = cyc;
            end
        end
    end

    function automatic logic [13:0] ev(input logic imem, dmem, mr, mw, ir, pcw,
                                       pcs, as, rw, m2r, input logic [3:0] alu,
                                       input logic e);
        return {imem, dmem, mr, mw, ir, pcw, pcs, as, rw, m2r, alu, e};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step(input logic ack, input logic [13:0] e);
        mem_ack = ack;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic haltCycles();
        for (int i = 0; i < 3; i++)
            step(logic'(i % 2), ev(0,0,0,0,0,0,0,0,0,0,4'b0000,1));
    endtask

    // Expand one instruction into its expected cycle-by-cycle control trace.
    task automatic runInstr(input logic [10:0] op, input logic z, input int fWait,
                            input int mWait, output bit halted);
        int kind;  // 0 illegal, 1 load, 2 store, 3 cbz, 4 reg ALU, 5 imm ALU
        logic [3:0] alu;
        opcode = op;
        zero_E = z;
        halted = 0;
        kind = 0;
        alu = 4'b0010;
        for (int i = 0; i < fWait && i < TIMEOUT; i++)
            step(0, ev(1,0,0,0,0,0,0,0,0,0,4'b0000,0));
        if (fWait >= TIMEOUT) begin
            haltCycles();
            halted = 1;
            return;
        end
        step(1, ev(1,0,0,0,1,1,0,0,0,0,4'b0000,0));
        step(1, ev(0,0,0,0,0,0,0,0,0,0,4'b0000,0));
        casez (op)
            11'b11111000010: kind = 1;
            11'b11111000000: kind = 2;
            11'b10110100???: begin kind = 3; alu = 4'b0111; end
            11'b10001011000: begin kind = 4; alu = 4'b0010; end
            11'b11001011000: begin kind = 4; alu = 4'b0110; end
            11'b10001010000: begin kind = 4; alu = 4'b0000; end
            11'b10101010000: begin kind = 4; alu = 4'b0001; end
`ifdef MULTICYCLE_IMM_EN
            11'b1001000100?: begin kind = 5; alu = 4'b0010; end
            11'b1101000100?: begin kind = 5; alu = 4'b0110; end
`endif
            default:         kind = 0;
        endcase
        if (kind == 0) begin
            haltCycles();
            halted = 1;
            return;
        end
        if (kind == 3)
            step(1, ev(0,0,0,0,0,z,z,0,0,0,alu,0));
        else
            step(1, ev(0,0,0,0,0,0,0,(kind != 4),0,0,alu,0));
        if (kind == 1 || kind == 2) begin
            for (int i = 0; i < mWait && i < TIMEOUT; i++)
                step(0, ev(0,1,(kind == 1),(kind == 2),0,0,0,0,0,0,4'b0000,0));
            if (mWait >= TIMEOUT) begin
                haltCycles();
                halted = 1;
                return;
            end
            step(1, ev(0,1,(kind == 1),(kind == 2),0,0,0,0,0,0,4'b0000,0));
        end
        if (kind == 1 || kind == 4 || kind == 5)
            step(1, ev(0,0,0,0,0,0,0,0,1,(kind == 1),4'b0000,0));
    endtask

    task automatic doReset();
        reset = 1'b0;
        #1;
        check("reset controls+err", 32'(actVec[12:0]), 32'h0);
        @(negedge clk);
        check("reset held controls+err", 32'(actVec[12:0]), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("imem_req after reset", 32'(imem_req), 32'h1);
    endtask

    initial begin
        bit h;
        int d0, w0, r0;
        #2;
        doReset();

        runInstr(OP_ADD, 0, 0, 0, h);
        runInstr(OP_SUB, 0, 0, 0, h);
        check("ADD length", 32'(gap), 32'd4);
        runInstr(OP_AND, 0, 0, 0, h);
        runInstr(OP_ORR, 0, 0, 0, h);
        runInstr(OP_LDUR, 0, 0, 0, h);
        runInstr(OP_STUR, 0, 0, 0, h);
        check("LDUR length", 32'(gap), 32'd5);
        runInstr(OP_CBZ, 1, 0, 0, h);
        check("STUR length", 32'(gap), 32'd4);
        runInstr(OP_CBZ, 0, 0, 0, h);
        check("CBZ length", 32'(gap), 32'd3);

        d0 = dmemCount;
        runInstr(OP_LDUR, 0, 0, 3, h);
        check("LDUR dmem_req cycles", 32'(dmemCount - d0), 32'd4);
        runInstr(OP_STUR, 0, 0, 2, h);
        runInstr(OP_ADD, 0, TIMEOUT - 1, 0, h);
        check("ack on last wait cycle err", 32'(err), 32'h0);

        runInstr(OP_ADDI, 0, 0, 0, h);
        if (h) doReset();
        runInstr(OP_SUBI, 0, 0, 0, h);
        if (h) doReset();

        runInstr(OP_BAD, 0, 0, 0, h);
        check("illegal err", 32'(err), 32'h1);
        check("illegal controls", 32'(actVec[13:1]), 32'h0);
        doReset();
        check("err cleared by reset", 32'(err), 32'h0);

        runInstr(OP_ADD, 0, TIMEOUT, 0, h);
        check("fetch timeout err", 32'(err), 32'h1);
        doReset();

        runInstr(OP_STUR, 0, 0, 20, h);
        check("mem timeout err", 32'(err), 32'h1);
        doReset();

        // Store interrupted by reset while waiting in MEM.
        opcode = OP_STUR;
        step(1, ev(1,0,0,0,1,1,0,0,0,0,4'b0000,0));
        step(1, ev(0,0,0,0,0,0,0,0,0,0,4'b0000,0));
        step(1, ev(0,0,0,0,0,0,0,1,0,0,4'b0010,0));
        step(0, ev(0,1,0,1,0,0,0,0,0,0,4'b0000,0));
        step(0, ev(0,1,0,1,0,0,0,0,0,0,4'b0000,0));
        mem_ack = 1'b0;
        #2;
        check("pre-reset memWrite", 32'({dmem_req, memWrite}), 32'h3);
        w0 = memWrCount;
        r0 = regWrCount;
        reset = 1'b0;
        #1;
        check("mid-MEM reset controls", 32'(actVec[12:0]), 32'h0);
        mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        check("no write pulse in reset", 32'(memWrCount - w0 + regWrCount - r0), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        runInstr(OP_ORR, 0, 0, 0, h);
        check("no write after reset", 32'(memWrCount - w0), 32'h0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, the maximum number of cycles a memory request may wait for mem_ack.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port opcode, input, 11 bits: instruction bits [31:21] from the instruction register.
REQ-005 SHALL have port zero_E, input, 1 bit: ALU zero flag from the execute stage.
REQ-006 SHALL have port mem_ack, input, 1 bit: memory completion strobe for the current request.
REQ-007 SHALL have ports imem_req and dmem_req, output, 1 bit each: instruction and data memory requests.
REQ-008 SHALL have ports memRead, memWrite, IRWrite, PCWrite, PCSrc, AluSrc, regWrite and memtoReg, output, 1 bit each: datapath controls.
REQ-009 SHALL have port AluControl, output, 4 bits: AND=0000, ORR=0001, ADD=0010, SUB=0110, PASSB=0111.
REQ-010 SHALL have port err, output, 1 bit: sticky fault flag.

Function
REQ-011 SHALL implement the states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-012 SHALL, in FETCH, hold imem_req=1; when mem_ack=1, pulse IRWrite=1 and PCWrite=1 (PC+4, PCSrc=0) in that cycle and move to DECODE.
REQ-013 SHALL, in DECODE, classify opcode and move to EXEC, or to HALT with err=1 if the opcode is illegal.
REQ-014 SHALL decode the following opcodes: LDUR 11111000010; STUR 11111000000; CBZ 10110100xxx; ADD 10001011000; SUB 11001011000; AND 10001010000; ORR 10101010000.
REQ-015 SHALL, in EXEC, drive AluSrc=1 and AluControl=0010 for LDUR/STUR, then go to MEM.
REQ-016 SHALL, in EXEC, drive AluSrc=0 and the matching AluControl for R-type, then go to WB.
REQ-017 SHALL, in EXEC for CBZ, drive AluSrc=0 and AluControl=0111; if zero_E=1, assert PCWrite=1 and PCSrc=1 for one cycle; then go to FETCH.
REQ-018 SHALL, in MEM, hold dmem_req=1 and memRead (LDUR) or memWrite (STUR) until mem_ack=1; then LDUR goes to WB and STUR goes to FETCH.
REQ-019 SHALL, in WB, assert regWrite=1 for one cycle (memtoReg=1 for LDUR, 0 for R-type) and return to FETCH.
REQ-020 SHALL hold every request high continuously until acknowledged, and SHALL ignore mem_ack outside FETCH and MEM.
REQ-021 SHALL count wait cycles with a counter cleared on entry to FETCH or MEM; if TIMEOUT cycles elapse without mem_ack, go to HALT with err=1.
REQ-022 SHALL treat mem_ack on exactly the TIMEOUT-th cycle as a successful acknowledge.
REQ-023 SHALL, in HALT, drive every control output to 0 and keep err=1 until reset.
REQ-024 SHALL, with mem_ack tied high, take 4 cycles for R-type, 5 for LDUR, 4 for STUR and 3 for CBZ.
REQ-025 SHALL drive 0 on every control output not named for the current state.

Reset
REQ-026 SHALL, while reset=0 and regardless of clk, enter FETCH, clear the counter and err, and drive all outputs to 0 except imem_req.
REQ-027 SHALL drive imem_req=1 from the first cycle after reset is released.
REQ-028 SHALL abandon any in-flight request when reset asserts mid-operation, with no write pulse emitted.

Configuration
REQ-029 SHALL, with MULTICYCLE_IMM_EN defined, also decode ADDI 1001000100x and SUBI 1101000100x, executed with AluSrc=1, AluControl 0010/0110, then WB with memtoReg=0.
REQ-030 SHALL, without MULTICYCLE_IMM_EN, treat ADDI and SUBI as illegal (HALT, err=1).

Verification
REQ-031 SHALL cover: opcode=10001011000 (ADD), mem_ack=1 -> FETCH, DECODE, EXEC (AluSrc=0, AluControl=0010), WB (regWrite=1); back in FETCH at cycle 5.
REQ-032 SHALL cover: LDUR with mem_ack held low 3 cycles in MEM -> dmem_req and memRead stay 1 four cycles; then WB with regWrite=1, memtoReg=1.
REQ-033 SHALL cover: CBZ with zero_E=1 -> EXEC AluControl=0111, PCWrite=1, PCSrc=1; with zero_E=0 -> PCWrite=0; next state FETCH.
REQ-034 SHALL cover: opcode=11111111111 -> HALT, err=1, all controls 0; remains so until reset=0, after which err=0 and the state is FETCH.
REQ-035 SHALL cover: mem_ack never asserted in FETCH -> err=1 after 15 cycles; mem_ack on cycle 15 -> no error.
REQ-036 SHALL cover: reset=0 asserted mid-MEM between clock edges -> outputs drop to 0 immediately; no memWrite or regWrite pulse.
